// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential signed multiply/divide engine.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic OP_MULT    = 1'b0;
  localparam logic OP_DIV     = 1'b1;
  localparam int   DEF_DATA_W = 32;

  // Wide enough to hold the iteration count DATA_W itself.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_DATA_W);

endpackage

// File: rtl/mult_div_div_step.sv
// One restoring-division step on magnitudes: shifted partial remainder vs divisor.
module div_step
  import mult_div_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W:0]   rem_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  // rem_in is below 2*divisor, so a successful subtraction always fits in DATA_W bits.
  always_comb begin
    q_bit   = (rem_in >= {1'b0, divisor});
    rem_out = q_bit ? (rem_in[DATA_W-1:0] - divisor) : rem_in[DATA_W-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed MULT (radix-2 Booth) / DIV (restoring) engine owning HI/LO.
// Define MULT_DIV_FAST_MULT_EN to replace the Booth loop with a single-cycle multiply.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] HI_out,
  output logic [DATA_W-1:0] LO_out
);

  localparam int            CW   = cnt_width(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_t state, next_state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mcand;
  logic [2*DATA_W:0] acc;
  logic              booth_bit;
  logic [DATA_W-1:0] divisor, rem, quo;
  logic              sign_a, sign_b;

  logic              load, commit_mult, commit_div, zero_set;
  logic [DATA_W:0]   mcand_ext, booth_hi;
  logic [2*DATA_W:0] booth_sum, acc_next;
  logic [DATA_W-1:0] rem_next, quo_next, quo_fix, rem_fix;
  logic              q_bit;

`ifdef MULT_DIV_FAST_MULT_EN
  logic                        commit_fast;
  logic signed [2*DATA_W-1:0] fast_prod;
  assign fast_prod = $signed(A) * $signed(B);
`endif

  // Booth step: the accumulator's upper part carries one guard bit so INT_MIN multiplicands cannot overflow.
  always_comb begin
    mcand_ext = {mcand[DATA_W-1], mcand};
    booth_hi  = acc[2*DATA_W:DATA_W];
    case ({acc[0], booth_bit})
      2'b10:   booth_hi = booth_hi - mcand_ext;
      2'b01:   booth_hi = booth_hi + mcand_ext;
      default: booth_hi = acc[2*DATA_W:DATA_W];
    endcase
    booth_sum = {booth_hi, acc[DATA_W-1:0]};
    acc_next  = {booth_sum[2*DATA_W], booth_sum[2*DATA_W:1]};
  end

  div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_in  ({rem, quo[DATA_W-1]}),
    .divisor (divisor),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // Quotient is negative when operand signs differ; remainder follows the dividend.
  always_comb begin
    quo_next = {quo[DATA_W-2:0], q_bit};
    quo_fix  = (sign_a ^ sign_b) ? -quo_next : quo_next;
    rem_fix  = sign_a ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_DIV) next_state = (B == '0) ? FINISH : DIV;
`ifdef MULT_DIV_FAST_MULT_EN
          else              next_state = FINISH;
`else
          else              next_state = MULT;
`endif
        end
      end
      MULT, DIV: if (cnt == LAST) next_state = FINISH;
      FINISH:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    load        = 1'b0;
    commit_mult = 1'b0;
    commit_div  = 1'b0;
    zero_set    = 1'b0;
`ifdef MULT_DIV_FAST_MULT_EN
    commit_fast = 1'b0;
`endif
    case (state)
      IDLE: begin
        load     = start;
        zero_set = start && (op == OP_DIV) && (B == '0);
`ifdef MULT_DIV_FAST_MULT_EN
        commit_fast = start && (op == OP_MULT);
`endif
      end
      MULT:    commit_mult = (cnt == LAST);
      DIV:     commit_div  = (cnt == LAST);
      default: load        = 1'b0;
    endcase
  end

  // Status flags are registered from the next state so done/div_zero are clean one-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      busy     <= (next_state != IDLE);
      done     <= (next_state == FINISH);
      div_zero <= zero_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      booth_bit <= 1'b0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
    end else if (load) begin
      cnt       <= '0;
      mcand     <= A;
      acc       <= {{(DATA_W+1){1'b0}}, B};
      booth_bit <= 1'b0;
      divisor   <= B[DATA_W-1] ? -B : B;
      rem       <= '0;
      quo       <= A[DATA_W-1] ? -A : A;
      sign_a    <= A[DATA_W-1];
      sign_b    <= B[DATA_W-1];
    end else if (state == MULT) begin
      cnt       <= cnt + 1'b1;
      acc       <= acc_next;
      booth_bit <= booth_sum[0];
    end else if (state == DIV) begin
      cnt <= cnt + 1'b1;
      rem <= rem_next;
      quo <= quo_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI_out <= '0;
      LO_out <= '0;
    end else if (commit_mult) begin
      {HI_out, LO_out} <= acc_next[2*DATA_W-1:0];
    end else if (commit_div) begin
      HI_out <= rem_fix;
      LO_out <= quo_fix;
    end
`ifdef MULT_DIV_FAST_MULT_EN
    else if (commit_fast) begin
      {HI_out, LO_out} <= fast_prod;
    end
`endif
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model plus directed literal checks.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, op;
  logic [W-1:0] A, B;
  logic         busy, done, div_zero;
  logic [W-1:0] HI_out, LO_out;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .HI_out   (HI_out),
    .LO_out   (LO_out)
  );

  // Reference model: a request accepted while idle keeps the unit busy for a fixed
  // number of cycles and posts its result in the last one.
  int           left   = 0;
  logic [W-1:0] m_hi   = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit           e_done = 1'b0, e_zero = 1'b0;

  function automatic void modelCalc(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!o) begin
      r = sa * sb;
      {hi, lo} = r;
    end else begin
      lo = W'(sa / sb);
      hi = W'(sa % sb);
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      left   = 0;
      m_hi   = '0;
      m_lo   = '0;
      e_done = 1'b0;
      e_zero = 1'b0;
    end else begin
      e_done = 1'b0;
      e_zero = 1'b0;
      if (left > 0) begin
        left--;
        if (left == 1) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          e_done = 1'b1;
        end
      end else if (start) begin
        if (op && B == '0) begin
          left   = 1;
          e_done = 1'b1;
          e_zero = 1'b1;
        end else begin
          left = W + 1;
          modelCalc(op, A, B, p_hi, p_lo);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("busy", W'(busy), W'(left > 0));
        checkOutput("done", W'(done), W'(e_done));
        checkOutput("div_zero", W'(div_zero), W'(e_zero));
        checkOutput("hi", HI_out, m_hi);
        checkOutput("lo", LO_out, m_lo);
      end
    end
  end

  // Pulses start, scrambles A/B afterwards, waits (bounded) for done and returns to IDLE.
  task automatic applyStimulus(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int exp_cycles, output logic dz);
    int n;
    op    = o;
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    n     = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    dz = div_zero;
    checkOutput("latency", W'(n), W'(exp_cycles));
    @(negedge clk);
  endtask

  typedef struct {
    logic         o;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t extra[4] = '{
    '{1'b0, 32'hFFFFFFFF, 32'h7FFFFFFF},
    '{1'b0, 32'h12345678, 32'h9ABCDEF0},
    '{1'b1, 32'h80000000, 32'h00000003},
    '{1'b1, 32'h00000005, 32'h00000009}
  };

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic dz;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_busy", W'(busy), '0);
    checkOutput("reset_done", W'(done), '0);
    checkOutput("reset_hi", HI_out, '0);
    checkOutput("reset_lo", LO_out, '0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 32'd7, 32'hFFFFFFFD, 33, dz);
    checkOutput("t1_hi", HI_out, 32'hFFFFFFFF);
    checkOutput("t1_lo", LO_out, 32'hFFFFFFEB);

    applyStimulus(1'b0, 32'h80000000, 32'h80000000, 33, dz);
    checkOutput("t2_hi", HI_out, 32'h40000000);
    checkOutput("t2_lo", LO_out, 32'h00000000);

    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, 33, dz);
    checkOutput("t3a_lo", LO_out, 32'hFFFFFFFD);
    checkOutput("t3a_hi", HI_out, 32'hFFFFFFFF);
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, 33, dz);
    checkOutput("t3b_lo", LO_out, 32'hFFFFFFFD);
    checkOutput("t3b_hi", HI_out, 32'h00000001);

    applyStimulus(1'b1, 32'h0ACF1234, 32'h00002000, 33, dz);
    checkOutput("t4_pre_hi", HI_out, 32'h00001234);
    checkOutput("t4_pre_lo", LO_out, 32'h00005678);
    applyStimulus(1'b1, 32'h00000055, 32'h00000000, 1, dz);
    checkOutput("t4_divzero", W'(dz), W'(1));
    checkOutput("t4_hi", HI_out, 32'h00001234);
    checkOutput("t4_lo", LO_out, 32'h00005678);

    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 33, dz);
    checkOutput("t5_lo", LO_out, 32'h80000000);
    checkOutput("t5_hi", HI_out, 32'h00000000);
    checkOutput("t5_divzero", W'(dz), '0);

    foreach (extra[i]) applyStimulus(extra[i].o, extra[i].a, extra[i].b, 33, dz);

    applyStimulus(1'b1, 32'h0ACF1234, 32'h00002000, 33, dz);
    op    = 1'b0;
    A     = 32'd5;
    B     = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    op    = 1'b1;
    B     = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("t6_busy_pre", W'(busy), W'(1));
    #1 reset = 1'b1;
    #1;
    checkOutput("t6_busy", W'(busy), '0);
    checkOutput("t6_done", W'(done), '0);
    checkOutput("t6_hi", HI_out, '0);
    checkOutput("t6_lo", LO_out, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 32'd3, 32'd4, 33, dz);
    checkOutput("t6_mult_lo", LO_out, 32'h0000000C);
    checkOutput("t6_mult_hi", HI_out, 32'h00000000);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
